// File: rtl/fsm_seq_param_if.sv
// Handshake and bus signals of the fsm_seq_param sequencer.
// Requests and operands (go, jmp, sk, dwell) go from the master to the sequencer.
// Status (y, busy, done, jmp_cnt) goes from the sequencer back to the master.
// The width parameters must match those given to the fsm_seq_param instance.
interface fsm_seq_param_if #(
    parameter int SK_W  = 2,
    parameter int DW_W  = 4,
    parameter int OUT_W = 3,
    parameter int JC_W  = 8
) ();
    logic             go;
    logic             jmp;
    logic [SK_W-1:0]  sk;
    logic [DW_W-1:0]  dwell;
    logic [OUT_W-1:0] y;
    logic             busy;
    logic             done;
    logic [JC_W-1:0]  jmp_cnt;

    modport master (
        output go, jmp, sk, dwell,
        input  y, busy, done, jmp_cnt
    );

    modport slave (
        input  go, jmp, sk, dwell,
        output y, busy, done, jmp_cnt
    );
endinterface

// File: rtl/fsm_seq_param.sv
// Parameterised phase sequencer:
// IDLE -> RUN/JMP -> DECODE -> STEP* -> HOLD -> FINAL -> IDLE.
// A jump request diverts the sequence into JMP from any active state.
// Every entry into JMP is counted in a saturating counter.
// Ports:
//   clk - sole clock, rising edge
//   rst - synchronous, active-high reset
//   bus - slave side of fsm_seq_param_if:
//         go, jmp, sk and dwell are inputs;
//         y, busy, done and jmp_cnt are registered outputs.
// Each output reflects the state entered at the same clock edge.
module fsm_seq_param #(
    parameter int SK_W  = 2,
    parameter int DW_W  = 4,
    parameter int OUT_W = 3,
    parameter int JC_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    fsm_seq_param_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        JMP    = 3'd2,
        DECODE = 3'd3,
        STEP   = 3'd4,
        HOLD   = 3'd5,
        FINAL  = 3'd6
    } state_t;

    state_t           state, state_nxt;
    logic [SK_W-1:0]  st_cnt, st_cnt_nxt;
    logic [DW_W-1:0]  dw_cnt, dw_cnt_nxt;
    logic [OUT_W-1:0] y_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [JC_W-1:0]  jc_nxt;

    // Decrement that stops at zero, so a counter can never wrap.
    function automatic logic [SK_W-1:0] sk_dec(input logic [SK_W-1:0] v);
        return (v == '0) ? v : v - SK_W'(1);
    endfunction

    function automatic logic [DW_W-1:0] dw_dec(input logic [DW_W-1:0] v);
        return (v == '0) ? v : v - DW_W'(1);
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [JC_W-1:0] jc_inc(input logic [JC_W-1:0] v);
        return (&v) ? v : v + JC_W'(1);
    endfunction

    // Next state and counter updates.
    always_comb begin
        state_nxt  = state;
        st_cnt_nxt = st_cnt;
        dw_cnt_nxt = dw_cnt;
        case (state)
            IDLE: begin
                if (bus.go) state_nxt = bus.jmp ? JMP : RUN;
            end
            RUN: state_nxt = DECODE;
            JMP: begin
                if (!bus.jmp) state_nxt = DECODE;
            end
            DECODE: begin
                if (bus.sk == '0) begin
                    state_nxt  = HOLD;
                    dw_cnt_nxt = bus.dwell;
                end else begin
                    state_nxt  = STEP;
                    st_cnt_nxt = bus.sk;
                end
            end
            STEP: begin
                st_cnt_nxt = sk_dec(st_cnt);
                // A value of 0 cannot normally occur here.
                // Treating it like 1 keeps a corrupted counter from parking the FSM in STEP.
                if (st_cnt <= SK_W'(1)) begin
                    state_nxt  = HOLD;
                    dw_cnt_nxt = bus.dwell;
                end
            end
            HOLD: begin
                dw_cnt_nxt = dw_dec(dw_cnt);
                // The exit test uses the post-decrement value.
                // As a result HOLD lasts max(dwell,1) cycles before go is honoured.
                if (dw_cnt_nxt == '0 && bus.go) state_nxt = FINAL;
            end
            FINAL: state_nxt = IDLE;
            default: begin
                state_nxt  = IDLE;
                st_cnt_nxt = '0;
                dw_cnt_nxt = '0;
            end
        endcase

        // A jump request beats every other transition once the sequence is running.
        if (bus.jmp && (state inside {RUN, DECODE, STEP, HOLD, FINAL})) state_nxt = JMP;
    end

    // Output values for the state being entered.
    always_comb begin
        y_nxt = '0;
        case (state_nxt)
            RUN:    y_nxt = OUT_W'(1);
            JMP:    y_nxt = OUT_W'(3);
            DECODE: y_nxt = OUT_W'(2);
            // Show what the step counter will hold after this STEP cycle's decrement.
            STEP:   y_nxt = OUT_W'(sk_dec(st_cnt_nxt));
            HOLD:   y_nxt = '1;
            FINAL:  y_nxt = {1'b1, {(OUT_W-1){1'b0}}};
            default: y_nxt = '0;
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == FINAL) && (state_nxt == IDLE);
        jc_nxt   = bus.jmp_cnt;
        if (state_nxt == JMP && state != JMP) jc_nxt = jc_inc(bus.jmp_cnt);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            st_cnt      <= '0;
            dw_cnt      <= '0;
            bus.y       <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.jmp_cnt <= '0;
        end else begin
            state       <= state_nxt;
            st_cnt      <= st_cnt_nxt;
            dw_cnt      <= dw_cnt_nxt;
            bus.y       <= y_nxt;
            bus.busy    <= busy_nxt;
            bus.done    <= done_nxt;
            bus.jmp_cnt <= jc_nxt;
        end
    end

endmodule

// File: tb/tb_fsm_seq_param.sv
// Directed testbench for fsm_seq_param.
// Two instances receive the same stimulus:
//   dut_a uses the default parameters;
//   dut_b has JC_W=2, so its jump-counter saturation can be observed.
module tb_fsm_seq_param;
    logic       clk;
    logic       rst;
    logic       go;
    logic       jmp;
    logic [1:0] sk;
    logic [3:0] dwell;
    int         checks;
    int         errors;
    int         exp_jc_a;
    int         exp_jc_b;

    fsm_seq_param_if #(.SK_W(2), .DW_W(4), .OUT_W(3), .JC_W(8)) bus_a ();
    fsm_seq_param_if #(.SK_W(2), .DW_W(4), .OUT_W(3), .JC_W(2)) bus_b ();

    assign bus_a.go = go;
    assign bus_a.jmp = jmp;
    assign bus_a.sk = sk;
    assign bus_a.dwell = dwell;
    assign bus_b.go = go;
    assign bus_b.jmp = jmp;
    assign bus_b.sk = sk;
    assign bus_b.dwell = dwell;

    fsm_seq_param #(.SK_W(2), .DW_W(4), .OUT_W(3), .JC_W(8)) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    fsm_seq_param #(.SK_W(2), .DW_W(4), .OUT_W(3), .JC_W(2)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Jump-count reference model: +1 per JMP entry, saturating per instance width.
    task automatic jump_entered();
        exp_jc_a = (exp_jc_a == 255) ? 255 : exp_jc_a + 1;
        exp_jc_b = (exp_jc_b == 3) ? 3 : exp_jc_b + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        go = 1'b1;
        jmp = 1'b1;
        sk = 2'd3;
        dwell = 4'd7;
        tick();
        tick();
        checks++;
        if (bus_a.y !== 3'b000) begin
            errors++;
            $display("FAIL reset_y got %b want 000", bus_a.y);
        end
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b want 0 0", bus_a.busy, bus_a.done);
        end
        checks++;
        if (bus_a.jmp_cnt !== 8'd0 || bus_b.jmp_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_jc got %0d/%0d want 0/0", bus_a.jmp_cnt, bus_b.jmp_cnt);
        end
        rst = 1'b0;
        go = 1'b0;
        jmp = 1'b0;
        exp_jc_a = 0;
        exp_jc_b = 0;
    endtask

    task automatic test_nominal();
        logic [2:0] ey [0:9];
        logic       eb [0:9];
        logic       ed [0:9];
        ey = '{3'b001, 3'b010, 3'b001, 3'b000, 3'b111, 3'b111, 3'b111, 3'b100, 3'b000, 3'b000};
        eb = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        ed = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        go = 1'b1;
        jmp = 1'b0;
        sk = 2'd2;
        dwell = 4'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 7) go = 1'b0;
            checks++;
            if (bus_a.y !== ey[i] || bus_a.busy !== eb[i] || bus_a.done !== ed[i]) begin
                errors++;
                $display("FAIL nominal[%0d] got y=%b busy=%b done=%b want y=%b busy=%b done=%b",
                         i, bus_a.y, bus_a.busy, bus_a.done, ey[i], eb[i], ed[i]);
            end
        end
        checks++;
        if (bus_a.jmp_cnt !== 8'd0) begin
            errors++;
            $display("FAIL nominal_jc got %0d want 0", bus_a.jmp_cnt);
        end
    endtask

    task automatic test_hold_wait();
        go = 1'b1;
        sk = 2'd0;
        dwell = 4'd2;
        tick();
        go = 1'b0;
        checks++;
        if (bus_a.y !== 3'b001) begin
            errors++;
            $display("FAIL hold_run got %b want 001", bus_a.y);
        end
        tick();
        tick();
        checks++;
        if (bus_a.y !== 3'b111) begin
            errors++;
            $display("FAIL hold_entry got %b want 111", bus_a.y);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (bus_a.y !== 3'b111 || bus_a.busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_wait[%0d] got y=%b busy=%b want 111 1", i, bus_a.y, bus_a.busy);
            end
        end
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (bus_a.y !== 3'b100) begin
            errors++;
            $display("FAIL hold_release got %b want 100", bus_a.y);
        end
        tick();
        checks++;
        if (bus_a.done !== 1'b1 || bus_a.y !== 3'b000) begin
            errors++;
            $display("FAIL hold_done got done=%b y=%b want 1 000", bus_a.done, bus_a.y);
        end
        tick();
        checks++;
        if (bus_a.done !== 1'b0) begin
            errors++;
            $display("FAIL hold_done_pulse got %b want 0", bus_a.done);
        end
    endtask

    task automatic test_jmp_hold();
        logic [2:0] ey [0:3];
        ey = '{3'b010, 3'b010, 3'b001, 3'b000};
        go = 1'b1;
        sk = 2'd3;
        dwell = 4'd0;
        tick();
        go = 1'b0;
        tick();
        tick();
        checks++;
        if (bus_a.y !== 3'b010) begin
            errors++;
            $display("FAIL jh_step got %b want 010", bus_a.y);
        end
        jmp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) jump_entered();
            checks++;
            if (bus_a.y !== 3'b011 || bus_a.busy !== 1'b1 || int'(bus_a.jmp_cnt) != exp_jc_a) begin
                errors++;
                $display("FAIL jh_jmp[%0d] got y=%b busy=%b jc=%0d want 011 1 %0d",
                         i, bus_a.y, bus_a.busy, bus_a.jmp_cnt, exp_jc_a);
            end
        end
        jmp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus_a.y !== ey[i]) begin
                errors++;
                $display("FAIL jh_after[%0d] got %b want %b", i, bus_a.y, ey[i]);
            end
        end
        tick();
        checks++;
        if (bus_a.y !== 3'b111) begin
            errors++;
            $display("FAIL jh_hold got %b want 111", bus_a.y);
        end
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        checks++;
        if (bus_a.done !== 1'b1 || int'(bus_a.jmp_cnt) != exp_jc_a) begin
            errors++;
            $display("FAIL jh_end got done=%b jc=%0d want 1 %0d", bus_a.done, bus_a.jmp_cnt, exp_jc_a);
        end
    endtask

    task automatic test_jmp_sat();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_jc_a = 0;
        exp_jc_b = 0;
        sk = 2'd3;
        dwell = 4'd5;
        for (int i = 0; i < 5; i++) begin
            // Steer the FSM to a distinct state before each jump pulse:
            // IDLE, DECODE, STEP, HOLD, FINAL.
            case (i)
                0: ;
                1: tick();
                2: begin
                    tick();
                    tick();
                end
                3: begin
                    sk = 2'd0;
                    tick();
                    tick();
                end
                default: begin
                    dwell = 4'd0;
                    go = 1'b1;
                    tick();
                    tick();
                    tick();
                end
            endcase
            go = (i == 0) ? 1'b1 : go;
            jmp = 1'b1;
            tick();
            jump_entered();
            jmp = 1'b0;
            go = 1'b0;
            checks++;
            if (bus_a.y !== 3'b011 || bus_a.done !== 1'b0 ||
                int'(bus_b.jmp_cnt) != exp_jc_b || int'(bus_a.jmp_cnt) != exp_jc_a) begin
                errors++;
                $display("FAIL jsat[%0d] got y=%b done=%b jc2=%0d jc8=%0d want 011 0 %0d %0d",
                         i, bus_a.y, bus_a.done, bus_b.jmp_cnt, bus_a.jmp_cnt, exp_jc_b, exp_jc_a);
            end
        end
        tick();
        tick();
        checks++;
        if (bus_a.y !== 3'b111) begin
            errors++;
            $display("FAIL jsat_park got %b want 111", bus_a.y);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        go = 1'b1;
        jmp = 1'b1;
        tick();
        exp_jc_a = 0;
        exp_jc_b = 0;
        checks++;
        if (bus_a.y !== 3'b000 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 ||
            bus_a.jmp_cnt !== 8'd0 || bus_b.jmp_cnt !== 2'd0) begin
            errors++;
            $display("FAIL rmid got y=%b busy=%b done=%b jc=%0d/%0d want 000 0 0 0/0",
                     bus_a.y, bus_a.busy, bus_a.done, bus_a.jmp_cnt, bus_b.jmp_cnt);
        end
        rst = 1'b0;
        jmp = 1'b0;
        tick();
        checks++;
        if (bus_a.y !== 3'b001 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_restart got y=%b busy=%b want 001 1", bus_a.y, bus_a.busy);
        end
        go = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] ey [0:5];
        logic       ed [0:5];
        ey = '{3'b001, 3'b010, 3'b111, 3'b100, 3'b000, 3'b001};
        ed = '{0, 0, 0, 0, 1, 0};
        sk = 2'd0;
        dwell = 4'd0;
        go = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus_a.y !== ey[i] || bus_a.done !== ed[i]) begin
                errors++;
                $display("FAIL b2b[%0d] got y=%b done=%b want y=%b done=%b",
                         i, bus_a.y, bus_a.done, ey[i], ed[i]);
            end
        end
        go = 1'b0;
        jmp = 1'b1;
        tick();
        jump_entered();
        checks++;
        if (bus_a.y !== 3'b011 || int'(bus_a.jmp_cnt) != exp_jc_a) begin
            errors++;
            $display("FAIL b2b_runjmp got y=%b jc=%0d want 011 %0d", bus_a.y, bus_a.jmp_cnt, exp_jc_a);
        end
        jmp = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_jc_a = 0;
        exp_jc_b = 0;
        rst = 1'b1;
        go = 1'b0;
        jmp = 1'b0;
        sk = '0;
        dwell = '0;
        test_reset();
        test_nominal();
        test_hold_wait();
        test_jmp_hold();
        test_jmp_sat();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
